// File: rtl/truth_scan_pkg.sv
// Shared types and limits for the truth-table scanner.
package truth_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } scan_state_e;

  localparam int N_IN_MIN   = 1;
  localparam int N_IN_MAX   = 8;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  // Settle timer width, sized to hold SETTLE_MAX-1.
  localparam int TMR_W = $clog2(SETTLE_MAX + 1);

endpackage

// File: rtl/scan_settle_timer.sv
// Down-counter that holds each vector for SETTLE cycles.
// Loaded with SETTLE-1; expired is high on the last hold cycle.
module scan_settle_timer
  import truth_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(SETTLE - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Reload on a new vector, otherwise count down to zero and stop there.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps all 2**N_IN input vectors through an external DUT, captures its
// output into a truth table and compares it against a golden table.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | waiting for start, dut_in held at 0
// ST_APPLY  | driving vector idx for SETTLE cycles
// ST_SAMPLE | capture dut_y for idx, compare, advance idx
// ST_FINISH | one-cycle done pulse, pass reflects err_cnt == 0
module truth_table_scanner
  import truth_scan_pkg::*;
#(
  parameter  int N_IN   = 3,
  parameter  int SETTLE = 1,
  localparam int NV     = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [NV-1:0]   expected,
  input  logic            dut_y,
  output logic [N_IN-1:0] dut_in,
  output logic            busy,
  output logic            done,
  output logic [NV-1:0]   table_out,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err,
  output logic            pass
);

  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NV - 1);
  localparam logic [N_IN:0]   ERR_MAX  = (N_IN + 1)'(NV);

  scan_state_e state_q, state_d;

  logic [N_IN-1:0] idx_q, idx_d;
  logic [NV-1:0]   table_q, table_d;
  logic [N_IN:0]   err_cnt_q, err_cnt_d;
  logic [N_IN-1:0] first_err_q, first_err_d;
  logic            pass_q, pass_d;

  logic tmr_load;
  logic tmr_expired;
  logic go;
  logic last_vec;

  // abort outranks start in IDLE, so a simultaneous pair never launches a sweep.
  assign go       = (state_q == ST_IDLE) && start && !abort;
  assign last_vec = (idx_q == IDX_LAST);

  // Timer reloads on every entry into APPLY.
  assign tmr_load = go || ((state_q == ST_SAMPLE) && !abort && !last_vec);

  scan_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .en      (state_q == ST_APPLY),
    .expired (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (go) state_d = ST_APPLY;
      ST_APPLY: begin
        if (abort)            state_d = ST_IDLE;
        else if (tmr_expired) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)         state_d = ST_IDLE;
        else if (last_vec) state_d = ST_FINISH;
        else               state_d = ST_APPLY;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    dut_in = '0;
    unique case (state_q)
      ST_APPLY, ST_SAMPLE: begin
        busy   = 1'b1;
        dut_in = idx_q;
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // Result datapath: clear on accepted start, update on each non-aborted sample.
  // An abort in SAMPLE drops that sample so the partial results stay untouched.
  always_comb begin
    idx_d       = idx_q;
    table_d     = table_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    if (go) begin
      idx_d       = '0;
      table_d     = '0;
      err_cnt_d   = '0;
      first_err_d = '0;
      pass_d      = 1'b0;
    end else if ((state_q == ST_SAMPLE) && !abort) begin
      table_d[idx_q] = dut_y;
      if (dut_y != expected[idx_q]) begin
        if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
        if (err_cnt_q == '0)      first_err_d = idx_q;
      end
      if (last_vec) pass_d = (err_cnt_d == '0);
      else          idx_d  = idx_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      table_q     <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      table_q     <= table_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  assign table_out = table_q;
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (N_IN=3/SETTLE=1 and
// N_IN=4/SETTLE=3) each driving a table-defined DUT, checked against a
// reference model computed directly from the golden and DUT tables.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, abort_a, start_b, abort_b;
  logic [7:0]  fn_a, exp_a;
  logic [15:0] fn_b, exp_b;

  logic [2:0] dut_in_a;  logic busy_a, done_a, pass_a;
  logic [7:0] table_a;   logic [3:0] err_a;  logic [2:0] first_a;
  logic [3:0] dut_in_b;  logic busy_b, done_b, pass_b;
  logic [15:0] table_b;  logic [4:0] err_b;  logic [3:0] first_b;
  logic y_a, y_b;

  assign y_a = fn_a[dut_in_a];
  assign y_b = fn_b[dut_in_b];

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .expected(exp_a), .dut_y(y_a), .dut_in(dut_in_a), .busy(busy_a),
    .done(done_a), .table_out(table_a), .err_cnt(err_a),
    .first_err(first_a), .pass(pass_a));

  truth_table_scanner #(.N_IN(4), .SETTLE(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .expected(exp_b), .dut_y(y_b), .dut_in(dut_in_b), .busy(busy_b),
    .done(done_b), .table_out(table_b), .err_cnt(err_b),
    .first_err(first_b), .pass(pass_b));

  int sel;
  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] o_table;
  logic [4:0]  o_err;
  logic [3:0]  o_first, o_dut_in;
  logic        o_busy, o_done, o_pass;

  assign o_table  = (sel == 0) ? {8'h00, table_a} : table_b;
  assign o_err    = (sel == 0) ? {1'b0, err_a}    : err_b;
  assign o_first  = (sel == 0) ? {1'b0, first_a}  : first_b;
  assign o_dut_in = (sel == 0) ? {1'b0, dut_in_a} : dut_in_b;
  assign o_busy   = (sel == 0) ? busy_a : busy_b;
  assign o_done   = (sel == 0) ? done_a : done_b;
  assign o_pass   = (sel == 0) ? pass_a : pass_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  task automatic set_abort(input logic v);
    if (sel == 0) abort_a = v; else abort_b = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: captured table is the DUT table itself, errors are the
  // differing bits, first error is the lowest differing index.
  task automatic ref_model(input int nv, input logic [15:0] fn, input logic [15:0] ex,
                           output logic [15:0] tbl, output int errs, output int first);
    errs  = 0;
    first = 0;
    tbl   = '0;
    for (int k = 0; k < nv; k++) begin
      tbl[k] = fn[k];
      if (fn[k] != ex[k]) begin
        if (errs == 0) first = k;
        errs++;
      end
    end
  endtask

  // Launch a sweep (caller sits #1 after a posedge) and return with n = 1.
  task automatic launch(output int n);
    set_start(1'b1);
    step();
    set_start(1'b0);
    n = 1;
  endtask

  task automatic full_sweep(input string tag, input logic [15:0] fn, input logic [15:0] ex,
                            input int stray_start_at);
    int nv, settle, n, errs, first;
    logic [15:0] tbl;
    nv     = (sel == 0) ? 8 : 16;
    settle = (sel == 0) ? 1 : 3;
    if (sel == 0) begin fn_a = fn[7:0]; exp_a = ex[7:0]; end
    else          begin fn_b = fn;      exp_b = ex;      end
    ref_model(nv, fn, ex, tbl, errs, first);
    launch(n);
    chk({tag, "_busy_start"}, 32'(o_busy), 32'd1);
    chk({tag, "_pass_clr"}, 32'(o_pass), 32'd0);
    chk({tag, "_err_clr"}, 32'(o_err), 32'd0);
    while (o_done !== 1'b1 && n < 300) begin
      if (n == stray_start_at) set_start(1'b1);
      step();
      set_start(1'b0);
      n++;
    end
    chk({tag, "_done_cycle"}, 32'(n), 32'(nv * (settle + 1) + 1));
    chk({tag, "_busy_fin"}, 32'(o_busy), 32'd0);
    chk({tag, "_table"}, 32'(o_table), 32'(tbl));
    chk({tag, "_err_cnt"}, 32'(o_err), 32'(errs));
    chk({tag, "_first_err"}, 32'(o_first), 32'(first));
    chk({tag, "_pass"}, 32'(o_pass), 32'(errs == 0));
    step();
    step();
    chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    chk({tag, "_table_hold"}, 32'(o_table), 32'(tbl));
    chk({tag, "_pass_hold"}, 32'(o_pass), 32'(errs == 0));
  endtask

  function automatic logic [15:0] and_or_fn();
    logic [15:0] f;
    logic [2:0]  v;
    f = '0;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      f[k] = (v[2] & v[1]) | v[0];
    end
    return f;
  endfunction

  function automatic logic [15:0] parity_fn();
    logic [15:0] f;
    logic [3:0]  v;
    f = '0;
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      f[k] = ^v;
    end
    return f;
  endfunction

  initial begin
    int n;
    logic [15:0] r_fn, r_ex;
    sel = 0;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    fn_a = '0; exp_a = '0; fn_b = '0; exp_b = '0;
    #1;
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_outs_a", {table_a, err_a, first_a, dut_in_a, pass_a, done_a}, 32'd0);
    chk("rst_outs_b", {table_b, err_b, first_b, dut_in_b, pass_b, done_b, busy_b}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // (a&b)|c, matching and single-error golden tables
    sel = 0;
    full_sweep("a_ok", and_or_fn(), 16'h00EA, -1);
    full_sweep("a_e8", and_or_fn(), 16'h00E8, -1);
    chk("a_e8_direct", {28'd0, err_a}, 32'd1);
    // all vectors wrong: err_cnt reaches NV
    full_sweep("a_all_bad", 16'h0035, 16'h00CA, -1);
    // start while busy is ignored
    full_sweep("a_stray", and_or_fn(), 16'h00EA, 5);

    // parity, N_IN=4, SETTLE=3
    sel = 1;
    full_sweep("b_par", parity_fn(), 16'h6996, -1);

    for (int i = 0; i < 4; i++) begin
      sel = 0;
      r_fn = 16'($urandom_range(0, 255));
      r_ex = 16'($urandom_range(0, 255));
      full_sweep("a_rand", r_fn, r_ex, -1);
      sel = 1;
      r_fn = 16'($urandom_range(0, 65535));
      r_ex = 16'($urandom_range(0, 65535));
      full_sweep("b_rand", r_fn, r_ex, int'($urandom_range(2, 40)));
    end

    // abort during vector 4
    sel = 0;
    fn_a = and_or_fn()[7:0];
    exp_a = 8'hEA;
    launch(n);
    while (!(o_dut_in == 4'd4 && o_busy) && n < 100) begin
      step();
      n++;
    end
    chk("abort_reach_v4", 32'(o_dut_in), 32'd4);
    set_abort(1'b1);
    step();
    set_abort(1'b0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_table", 32'(o_table), 32'h0000000A);
    chk("abort_err", 32'(o_err), 32'd0);
    chk("abort_pass", 32'(o_pass), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_idle", {30'd0, o_done, o_busy}, 32'd0);
    end
    full_sweep("a_after_abort", and_or_fn(), 16'h00EA, -1);

    // abort and start together in IDLE
    set_start(1'b1);
    set_abort(1'b1);
    step();
    set_start(1'b0);
    set_abort(1'b0);
    chk("abort_start_busy", 32'(o_busy), 32'd0);
    chk("abort_start_pass_hold", 32'(o_pass), 32'd1);

    // stray start then reset mid-sweep at vector 2
    launch(n);
    set_start(1'b1);
    step();
    set_start(1'b0);
    n++;
    while (o_dut_in != 4'd2 && n < 100) begin
      step();
      n++;
    end
    chk("rst_mid_reach_v2", 32'(o_dut_in), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs_a", {table_a, err_a, first_a, dut_in_a, pass_a, done_a, busy_a}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid_idle", {27'd0, o_dut_in, o_busy}, 32'd0);
    end
    full_sweep("a_after_rst", and_or_fn(), 16'h00E8, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter N_IN, default 3, SHALL set the number of DUT inputs swept (1..8).
REQ-002 Parameter SETTLE, default 1, SHALL set the number of cycles each vector is held before sampling (1..15).
REQ-003 Derived constant NV = 2**N_IN SHALL be the vector count.
REQ-004 clk  in  1  the single clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  request a full sweep; sampled only in IDLE.
REQ-007 abort  in  1  synchronous sweep cancel.
REQ-008 expected  in  NV  golden truth table; bit k is the expected y for input vector k.
REQ-009 dut_y  in  1  DUT output under test.
REQ-010 dut_in  out  N_IN  vector driven to the DUT; MSB is the first DUT input ({a,b,c} order).
REQ-011 busy  out  1  high while a sweep is in progress.
REQ-012 done  out  1  one-cycle pulse when a sweep completes normally.
REQ-013 table_out  out  NV  captured truth table; bit k is dut_y sampled for vector k.
REQ-014 err_cnt  out  N_IN+1  number of vectors with dut_y != expected[k].
REQ-015 first_err  out  N_IN  lowest vector index that mismatched; 0 if none.
REQ-016 pass  out  1  high from done until the next start when err_cnt == 0.

Function
REQ-017 The FSM SHALL use states IDLE, APPLY, SAMPLE and FINISH.
REQ-018 IDLE: dut_in=0, busy=0; start=1 SHALL clear idx, table_out, err_cnt, first_err and pass, then go to APPLY.
REQ-019 APPLY: dut_in=idx, busy=1; held for exactly SETTLE cycles, then go to SAMPLE.
REQ-020 SAMPLE (1 cycle, dut_in still idx) SHALL write dut_y into table_out[idx]; if dut_y != expected[idx], err_cnt SHALL increment, and if it was 0, first_err SHALL load idx.
REQ-021 From SAMPLE: if idx == NV-1 go to FINISH; otherwise idx increments and the FSM returns to APPLY.
REQ-022 FINISH (1 cycle): done=1, busy=0, pass=(err_cnt==0); next state IDLE.
REQ-023 Timing: start accepted in cycle t; vector k is sampled in cycle t+(k+1)*(SETTLE+1); done=1 in cycle t+NV*(SETTLE+1)+1.
REQ-024 start while busy SHALL be ignored, with no effect on idx or results.
REQ-025 abort=1 in APPLY or SAMPLE SHALL return to IDLE next cycle, with no done pulse; partial table_out and err_cnt hold; pass stays 0.
REQ-026 abort and start in the same IDLE cycle: abort wins, no sweep starts.
REQ-027 table_out, err_cnt, first_err and pass SHALL hold after FINISH until the next accepted start.
REQ-028 err_cnt SHALL saturate at NV; idx SHALL never wrap past NV-1.

Reset
REQ-029 rst_n=0 SHALL force IDLE asynchronously and set dut_in=0, busy=0, done=0, table_out=0, err_cnt=0, first_err=0, pass=0.
REQ-030 Reset asserted mid-sweep SHALL discard progress; after release, the block SHALL wait in IDLE for a fresh start.

Structure
REQ-031 Package truth_scan_pkg SHALL hold the state enum type and the SETTLE/N_IN limit constants.
REQ-032 Sub-module scan_settle_timer SHALL implement the SETTLE-cycle hold counter (load, count-down, expire).

Verification
REQ-033 N_IN=3, SETTLE=1, DUT y=(a&b)|c, expected=8'hEA -> done at t+17, table_out=8'hEA, err_cnt=0, pass=1.
REQ-034 Same DUT, expected=8'hE8 -> err_cnt=1, first_err=1, pass=0.
REQ-035 N_IN=4, SETTLE=3, DUT y=parity, expected=16'h6996 -> done at t+65, pass=1.
REQ-036 abort at vector 4 -> IDLE next cycle, no done, table_out[7:4]=0; then start -> full sweep with the correct result.
REQ-037 start pulsed during a sweep, then rst_n low at vector 2 -> start has no effect; after reset all outputs are 0 and the block stays in IDLE until start.
